// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host deframer feeding a show-ahead scan-code FIFO.
// Optional PS2_BREAK_FILTER_EN drops 0xE0 prefixes and F0-prefixed key releases.
module ps2_scancode_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] code,
  output logic       empty,
  output logic       full,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Odd parity over data plus parity bit means the frame is good.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_prev_r;
  logic                   strobe_s;
  logic                   data_s;

  state_t         state_r;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic           parity_r;
  logic [TW-1:0]  to_cnt_r;
  logic           parity_err_r;
  logic           frame_err_r;
  logic           frame_ok_s;
  logic           push_s;

  logic [7:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic [7:0]     code_r;
  logic           empty_r;
  logic           full_r;
  logic           overflow_r;
  logic           pop_s;
  logic           wr_en_s;
  logic           overflow_s;
  logic [CW-1:0]  count_nxt_s;
  logic [AW-1:0]  rd_ptr_nxt_s;
  logic [7:0]     head_nxt_s;

  // Pad synchronizers and previous synced clock for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= '1;
      data_sync_r <= '1;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  assign strobe_s   = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
  assign data_s     = data_sync_r[SYNC_STAGES-1];
  assign frame_ok_s = strobe_s && (state_r == STOP) && data_s && parity_ok(shift_r, parity_r);

`ifdef PS2_BREAK_FILTER_EN
  logic break_pending_r;
  logic brk_set_s;
  logic brk_clr_s;

  // Suppress E0 prefixes and the byte following an F0 break code.
  always_comb begin
    push_s    = 1'b0;
    brk_set_s = 1'b0;
    brk_clr_s = 1'b0;
    if (frame_ok_s) begin
      if (shift_r == 8'hE0) begin
        push_s = 1'b0;
      end else if (break_pending_r) begin
        brk_clr_s = 1'b1;
      end else if (shift_r == 8'hF0) begin
        brk_set_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Break flag survives framing errors; only reset or the released key clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      break_pending_r <= 1'b0;
    end else if (brk_set_s) begin
      break_pending_r <= 1'b1;
    end else if (brk_clr_s) begin
      break_pending_r <= 1'b0;
    end
  end
`else
  // Every valid byte goes to the FIFO.
  always_comb begin
    push_s = frame_ok_s;
  end
`endif

  // Frame FSM with inactivity timeout and registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      parity_r     <= 1'b0;
      to_cnt_r     <= '0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (strobe_s) begin
        to_cnt_r <= '0;
        case (state_r)
          IDLE: begin
            if (!data_s) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
              shift_r   <= 8'h00;
            end
          end
          DATA: begin
            shift_r   <= {data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end
          end
          PARITY: begin
            parity_r <= data_s;
            state_r  <= STOP;
          end
          STOP: begin
            state_r <= IDLE;
            if (!data_s) begin
              frame_err_r <= 1'b1;
            end else if (!parity_ok(shift_r, parity_r)) begin
              parity_err_r <= 1'b1;
            end
          end
          default: state_r <= IDLE;
        endcase
      end else if (state_r != IDLE) begin
        if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
          state_r     <= IDLE;
          frame_err_r <= 1'b1;
          shift_r     <= 8'h00;
          to_cnt_r    <= '0;
        end else begin
          to_cnt_r <= to_cnt_r + TW'(1);
        end
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

  // FIFO control; the head register is preloaded with next cycle's head byte.
  always_comb begin
    pop_s        = rd & ~empty_r;
    wr_en_s      = push_s & (~full_r | pop_s);
    overflow_s   = push_s & full_r & ~pop_s;
    count_nxt_s  = count_r + CW'(wr_en_s) - CW'(pop_s);
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    if (count_nxt_s == '0) begin
      head_nxt_s = 8'h00;
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = shift_r;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // Pointers, occupancy and registered FIFO outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      code_r     <= 8'h00;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      code_r     <= head_nxt_s;
      empty_r    <= (count_nxt_s == '0);
      full_r     <= (count_nxt_s == CW'(FIFO_DEPTH));
      overflow_r <= overflow_s;
    end
  end

  assign code       = code_r;
  assign empty      = empty_r;
  assign full       = full_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overflow   = overflow_r;

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Upstream stage of the keyboard password checker. It deframes the 11-bit PS/2 device-to-host serial stream into 8-bit scan codes. Valid bytes are buffered in a small show-ahead FIFO. The downstream consumer sees the head byte on `code` whenever `empty` is low and pops it with `rd`.

Parameters:
- FIFO_DEPTH, 8, number of buffered scan codes; power of two, >= 2.
- SYNC_STAGES, 2, flip-flop stages synchronizing `ps2_clk` and `ps2_data`; >= 2.
- TIMEOUT_CYCLES, 5000, `clk` cycles without a `ps2_clk` falling edge before a partial frame is abandoned.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ps2_clk, input, 1, raw PS/2 clock from the pad, asynchronous.
- ps2_data, input, 1, raw PS/2 data from the pad, asynchronous.
- rd, input, 1, pop request; acts on the FIFO head when `empty` is 0.
- code, output, 8, FIFO head byte; valid only while `empty` is 0.
- empty, output, 1, FIFO holds no bytes.
- full, output, 1, FIFO holds FIFO_DEPTH bytes.
- parity_err, output, 1, one-cycle pulse: frame discarded for bad parity.
- frame_err, output, 1, one-cycle pulse: frame discarded for stop bit 0 or timeout.
- overflow, output, 1, one-cycle pulse: valid byte dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - `code`=0x00, `empty`=1, `full`=0, all pulses 0.
  - FSM in IDLE; bit counter, timeout counter and FIFO pointers cleared; sync chains to 1.
  - Reset mid-frame discards the partial frame; buffered bytes are lost.
- Sampling:
  - `ps2_clk` and `ps2_data` each pass through SYNC_STAGES flops.
  - A falling edge is synced clk 1 in the previous cycle and 0 now; it yields a one-cycle strobe.
  - Synced data is sampled only on the strobe.
- FSM (advances only on the strobe, except timeout):
  - IDLE: data=0 → DATA with bit count 0. Data=1 → stay in IDLE, no error.
  - DATA: shift the bit in LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: always → IDLE.
    - If stop bit = 1 and the 8 data bits plus the parity bit have odd parity → push the byte.
    - If stop bit = 1 and parity is even → pulse `parity_err`.
    - If stop bit = 0 → pulse `frame_err`; this takes priority over the parity check.
- Timeout:
  - The counter resets on every strobe and counts while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES-1 → IDLE, pulse `frame_err`, discard the partial byte.
- FIFO:
  - Show-ahead: `code` = mem[rd_ptr] while `empty` is 0.
  - A pushed byte appears on `code`, with `empty`=0, on the clock edge after the push cycle.
  - Pop when `rd`=1 and `empty`=0; `code` shows the next entry on the following edge.
  - `rd` while empty is ignored; no pointer change and no error.
  - Push while full with no pop → byte dropped, `overflow` pulses, contents unchanged.
  - Push and pop in the same cycle, including when full → both occur; count unchanged; `overflow`=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - `full`/`empty` come from a count of width clog2(FIFO_DEPTH)+1.
- Throughput: one byte per frame; frames arrive at least 11 PS/2 clock periods apart.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- When defined:
  - A valid 0xF0 byte is not pushed; instead it sets a `break_pending` flag.
  - The next valid byte clears the flag and is also not pushed, so key releases never reach the consumer.
  - 0xE0 prefixes are dropped unconditionally.
  - The flag clears on reset only; a parity or frame error leaves it unchanged.
- When undefined: every valid byte, including 0xF0 and 0xE0, is pushed unchanged.

Test Plan:
- Single frame 0x2C (bits 0,0,0,1,1,0,1,0,0, parity 0, stop 1) → `empty` falls 1 cycle after the stop-bit strobe; `code`=0x2C. Pulse `rd` → `empty`=1.
- Byte 0x24 sent with parity 0 → `parity_err` pulses once; `empty` stays 1. Next, 0x24 with parity 1 → `code`=0x24.
- 5 bits of a frame, then a stall longer than TIMEOUT_CYCLES (bench uses 200) → `frame_err` pulses once. A following full 0x1B frame is received correctly.
- 9 valid frames 0x01..0x09 with no reads → `full`=1 after the 8th; `overflow` pulses on the 9th. Reads return 0x01..0x08 in order; `empty`=1 after the 8th read.
- With FIFO full, a frame completes in the same cycle as `rd`=1 → `full` stays 1, no `overflow`, the new byte is last out.
- Frames F0, 2C, 24: with PS2_BREAK_FILTER_EN defined → only 0x24 is read; without it → 0xF0, 0x2C, 0x24. Separately, `rst_n` pulsed mid-frame → `empty`=1 and the next frame decodes cleanly.
